// File: rtl/mano_io_ctrl.sv
// Multi-channel Mano-style I/O controller: per-channel INPR/OUTR with FGI/FGO
// flags, CPU strobe interface, and a masked, registered interrupt request.
module mano_io_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NCH    = 2,
  parameter int unsigned SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  input  logic [SW-1:0]         cpu_sel,
  input  logic                  cpu_inp,
  input  logic                  cpu_out,
  input  logic                  cpu_ski,
  input  logic                  cpu_sko,
  input  logic                  cpu_ion,
  input  logic                  cpu_iof,
  input  logic                  cpu_msk_we,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_skip,
  output logic                  irq,
  output logic [SW-1:0]         irq_ch,
  input  logic                  irq_ack,
  output logic                  ien
);

  localparam int unsigned MW = 2 * NCH;

  logic [DATA_W-1:0] inpr_q [NCH];
  logic [DATA_W-1:0] inpr_d [NCH];
  logic [DATA_W-1:0] outr_q [NCH];
  logic [DATA_W-1:0] outr_d [NCH];
  logic [NCH-1:0]    fgi_q, fgi_d;
  logic [NCH-1:0]    fgo_q, fgo_d;
  logic [MW-1:0]     imsk_q, imsk_d;
  logic              ien_q, ien_d;
  logic              irq_q, irq_d;
  logic [SW-1:0]     irq_ch_q, irq_ch_d;
  logic [NCH-1:0]    pend;

  // Next-state: external handshakes, CPU strobes, mask, IEN and interrupt request.
  always_comb begin
    inpr_d   = inpr_q;
    outr_d   = outr_q;
    fgi_d    = fgi_q;
    fgo_d    = fgo_q;
    imsk_d   = imsk_q;
    ien_d    = ien_q;
    irq_ch_d = '0;

    for (int c = 0; c < NCH; c++) begin
      if (in_valid[c] && !fgi_q[c]) begin
        inpr_d[c] = in_data[c*DATA_W +: DATA_W];
        fgi_d[c]  = 1'b1;
      end
      if (out_ready[c] && !fgo_q[c]) begin
        fgo_d[c] = 1'b1;
      end
      // A select beyond NCH-1 matches no channel, so such strobes fall through.
      if (cpu_sel == SW'(c)) begin
        if (cpu_inp && fgi_q[c]) begin
          fgi_d[c] = 1'b0;
        end
        if (cpu_out && fgo_q[c]) begin
          outr_d[c] = cpu_wdata;
          fgo_d[c]  = 1'b0;
        end
      end
    end

    if (cpu_msk_we) begin
      imsk_d = cpu_wdata[MW-1:0];
    end

    if (irq_ack) begin
      ien_d = 1'b0;
    end else if (cpu_iof) begin
      ien_d = 1'b0;
    end else if (cpu_ion) begin
      ien_d = 1'b1;
    end

    pend  = (fgi_d & imsk_d[NCH-1:0]) | (fgo_d & imsk_d[MW-1:NCH]);
    irq_d = ien_d && (|pend) && !irq_ack;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        irq_ch_d = SW'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        inpr_q[c] <= '0;
        outr_q[c] <= '0;
      end
      fgi_q    <= '0;
      fgo_q    <= '1;
      imsk_q   <= '0;
      ien_q    <= 1'b0;
      irq_q    <= 1'b0;
      irq_ch_q <= '0;
    end else begin
      inpr_q   <= inpr_d;
      outr_q   <= outr_d;
      fgi_q    <= fgi_d;
      fgo_q    <= fgo_d;
      imsk_q   <= imsk_d;
      ien_q    <= ien_d;
      irq_q    <= irq_d;
      irq_ch_q <= irq_ch_d;
    end
  end

  // CPU read path and skip query, zero when the select addresses no channel.
  always_comb begin
    cpu_rdata = '0;
    cpu_skip  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cpu_sel == SW'(c)) begin
        cpu_rdata = inpr_q[c];
        cpu_skip  = (cpu_ski && fgi_q[c]) || (cpu_sko && fgo_q[c]);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < NCH; c++) begin
      out_data[c*DATA_W +: DATA_W] = outr_q[c];
    end
  end

  assign in_ready  = ~fgi_q;
  assign out_valid = ~fgo_q;
  assign irq       = irq_q;
  assign irq_ch    = irq_ch_q;
  assign ien       = ien_q;

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Directed, table-driven bench for mano_io_ctrl (DATA_W=8, NCH=2).
module tb_mano_io_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic        cpu_sel;
  logic        cpu_inp, cpu_out, cpu_ski, cpu_sko, cpu_ion, cpu_iof, cpu_msk_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_skip;
  logic        irq;
  logic        irq_ch;
  logic        irq_ack;
  logic        ien;

  int errors = 0;
  int checks = 0;

  mano_io_ctrl #(.DATA_W(8), .NCH(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_sel(cpu_sel), .cpu_inp(cpu_inp), .cpu_out(cpu_out),
    .cpu_ski(cpu_ski), .cpu_sko(cpu_sko), .cpu_ion(cpu_ion), .cpu_iof(cpu_iof),
    .cpu_msk_we(cpu_msk_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_skip(cpu_skip), .irq(irq), .irq_ch(irq_ch), .irq_ack(irq_ack), .ien(ien)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] din;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic        sel;
    logic        inp;
    logic        outs;
    logic        ski;
    logic        sko;
    logic        ion;
    logic        iof;
    logic        mwe;
    logic [7:0]  wd;
    logic        ack;
    logic [1:0]  e_ir;
    logic [1:0]  e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_rd;
    logic        e_sk;
    logic        e_irq;
    logic        e_ch;
    logic        e_ien;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_data = '0; in_valid = '0; out_ready = '0; cpu_sel = 1'b0;
    cpu_inp = 0; cpu_out = 0; cpu_ski = 0; cpu_sko = 0;
    cpu_ion = 0; cpu_iof = 0; cpu_msk_we = 0; cpu_wdata = '0; irq_ack = 0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".in_ready"},  32'(in_ready),  32'(v.e_ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, ".out_data"},  32'(out_data),  32'(v.e_od));
    check({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(v.e_rd));
    check({tag, ".cpu_skip"},  32'(cpu_skip),  32'(v.e_sk));
    check({tag, ".irq"},       32'(irq),       32'(v.e_irq));
    check({tag, ".irq_ch"},    32'(irq_ch),    32'(v.e_ch));
    check({tag, ".ien"},       32'(ien),       32'(v.e_ien));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t rv;
    //            din      iv     ordy  sel inp out ski sko ion iof mwe wd     ack  ir     ov     od        rd     sk irq ch ien
    vecs[0]  = '{16'hA500, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b01, 2'b00, 16'h0000, 8'h00, 0, 0, 0, 0};
    vecs[1]  = '{16'h0000, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b01, 2'b00, 16'h0000, 8'hA5, 1, 0, 0, 0};
    vecs[2]  = '{16'h0000, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 8'hA5, 0, 0, 0, 0};
    vecs[3]  = '{16'h0000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 0, 2'b11, 2'b01, 16'h003C, 8'h00, 0, 0, 0, 0};
    vecs[4]  = '{16'h0000, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h55, 0, 2'b11, 2'b01, 16'h003C, 8'h00, 0, 0, 0, 0};
    vecs[5]  = '{16'h0000, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 2'b11, 2'b00, 16'h003C, 8'h00, 1, 0, 0, 0};
    vecs[6]  = '{16'h0000, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b11, 2'b00, 16'h003C, 8'hA5, 0, 0, 0, 0};
    vecs[7]  = '{16'h0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 8'h03, 0, 2'b11, 2'b00, 16'h003C, 8'h00, 0, 0, 0, 1};
    vecs[8]  = '{16'h7712, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 16'h003C, 8'h12, 0, 1, 0, 1};
    vecs[9]  = '{16'h0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 2'b00, 2'b00, 16'h003C, 8'h12, 0, 0, 0, 0};
    vecs[10] = '{16'h0000, 2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 16'h003C, 8'h77, 1, 0, 0, 0};
    vecs[11] = '{16'h0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 2'b00, 2'b00, 16'h003C, 8'h12, 0, 1, 0, 1};
    vecs[12] = '{16'h0000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b01, 2'b00, 16'h003C, 8'h12, 0, 1, 1, 1};
    vecs[13] = '{16'h0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 2'b01, 2'b00, 16'h003C, 8'h12, 0, 0, 1, 0};
    vecs[14] = '{16'h0000, 2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0, 8'h9A, 0, 2'b11, 2'b10, 16'h9A3C, 8'h77, 0, 0, 0, 0};

    idle_inputs();
    rst = 1'b1;
    #3;
    rv = '{16'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 8'h00, 0, 0, 0, 0};
    check_all("reset", rv);
    @(negedge clk);
    rst = 1'b0;

    // Each vector is held across one rising edge; outputs sampled 1 time unit later.
    for (int i = 0; i < 15; i++) begin
      in_data = vecs[i].din; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      cpu_sel = vecs[i].sel; cpu_inp = vecs[i].inp; cpu_out = vecs[i].outs;
      cpu_ski = vecs[i].ski; cpu_sko = vecs[i].sko; cpu_ion = vecs[i].ion;
      cpu_iof = vecs[i].iof; cpu_msk_we = vecs[i].mwe; cpu_wdata = vecs[i].wd;
      irq_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Output masks right after reset: FGO comes out of reset set, so irq fires at once.
    do_reset();
    cpu_msk_we = 1; cpu_wdata = 8'h0C; cpu_ion = 1; cpu_sel = 1'b1; cpu_sko = 1;
    @(posedge clk);
    #1;
    check("msk0C.irq", 32'(irq), 32'd1);
    check("msk0C.irq_ch", 32'(irq_ch), 32'd0);
    check("msk0C.ien", 32'(ien), 32'd1);
    check("msk0C.skip", 32'(cpu_skip), 32'd1);

    // Asynchronous reset in the middle of held transfers.
    idle_inputs();
    in_data = 16'h00AB; in_valid = 2'b01;
    @(posedge clk);
    #1;
    idle_inputs();
    cpu_out = 1; cpu_wdata = 8'h11;
    @(posedge clk);
    #1;
    idle_inputs();
    check("pre_rst.in_ready", 32'(in_ready), 32'h2);
    check("pre_rst.out_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    rv = '{16'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b11, 2'b00, 16'h0000, 8'h00, 0, 0, 0, 0};
    check_all("async_rst", rv);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst", rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mano_io_ctrl.md
MANO_IO_CTRL -- requirements
Module: mano_io_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data width of INPR/OUTR per channel (legal range 8..16).
REQ-002 SHALL have parameter NCH, default 2, meaning number of I/O channels (legal range 1..4, 2*NCH <= DATA_W); SW = max(1, clog2(NCH)).
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NCH*DATA_W  external input device data, channel c at [c*DATA_W +: DATA_W].
- in_valid  in  NCH  external input word offered.
- in_ready  out  NCH  channel may accept an input word.
- out_data  out  NCH*DATA_W  OUTR contents per channel.
- out_valid  out  NCH  OUTR holds a word not yet taken.
- out_ready  in  NCH  external output device takes word.
- cpu_sel  in  SW  channel addressed by the CPU strobes.
- cpu_inp  in  1  INP strobe: read INPR[sel], clear FGI[sel].
- cpu_out  in  1  OUT strobe: write OUTR[sel].
- cpu_ski  in  1  skip-if-input-flag query.
- cpu_sko  in  1  skip-if-output-flag query.
- cpu_ion  in  1  set IEN.
- cpu_iof  in  1  clear IEN.
- cpu_msk_we  in  1  write interrupt mask.
- cpu_wdata  in  DATA_W  OUT data / mask data.
- cpu_rdata  out  DATA_W  INPR[sel].
- cpu_skip  out  1  skip condition true.
- irq  out  1  interrupt request (registered).
- irq_ch  out  SW  channel of the request (registered).
- irq_ack  in  1  CPU entered interrupt cycle.
- ien  out  1  interrupt-enable flag.

Function
REQ-004 Per channel c SHALL hold INPR[c], OUTR[c] (DATA_W), FGI[c], FGO[c]; globals IEN, IMSK (2*NCH bits: bit c = input mask c, bit NCH+c = output mask c).
REQ-005 in_ready[c] SHALL equal ~FGI[c]; on in_valid[c] & in_ready[c] at a clock edge, INPR[c] <= in_data slice, FGI[c] <= 1.
REQ-006 out_valid[c] SHALL equal ~FGO[c]; out_data slice c SHALL equal OUTR[c]; on out_valid[c] & out_ready[c], FGO[c] <= 1.
REQ-007 cpu_rdata SHALL combinationally equal INPR[cpu_sel]; cpu_inp with FGI[sel]=1 SHALL clear FGI[sel] at the edge; with FGI[sel]=0, no state change.
REQ-008 cpu_out with FGO[sel]=1 SHALL load OUTR[sel] <= cpu_wdata and clear FGO[sel]; with FGO[sel]=0 the write SHALL be ignored.
REQ-009 cpu_skip SHALL combinationally equal (cpu_ski & FGI[sel]) | (cpu_sko & FGO[sel]).
REQ-010 cpu_sel >= NCH: strobes ignored, cpu_rdata = 0, cpu_skip = 0.
REQ-011 cpu_inp and cpu_out in the same cycle SHALL both take effect.
REQ-012 cpu_msk_we SHALL load IMSK <= cpu_wdata[2*NCH-1:0].
REQ-013 IEN priority per edge: irq_ack clears > cpu_iof clears > cpu_ion sets > hold.
REQ-014 pend[c] = (FGI[c] & IMSK[c]) | (FGO[c] & IMSK[NCH+c]); irq SHALL register IEN_next & |pend & ~irq_ack, using flag values after the same edge's updates (one-cycle latency from flag set).
REQ-015 irq_ch SHALL register the lowest-index c with pend[c]=1; 0 when none pending.
REQ-016 Flag updates by external handshake and CPU strobe on the same channel cannot conflict (ready/valid gated by flags); REQ-005/006/007/008 SHALL apply independently.

Reset
REQ-017 While rst=1: INPR=OUTR=0, FGI=0, FGO=1 (all channels), IEN=0, IMSK=0, irq=0, irq_ch=0; hence in_ready=all 1, out_valid=all 0, ien=0.
REQ-018 rst asserted mid-transfer SHALL abort it immediately; no held word survives.

Verification
REQ-019 Reset -> in_ready=11, out_valid=00, irq=0, ien=0, cpu_skip=0 with ski=sko=0.
REQ-020 in_data ch1=0xA5, in_valid=10 one cycle -> FGI1=1, in_ready=01; sel=1, ski -> skip=1; cpu_inp -> rdata=0xA5, in_ready back to 11.
REQ-021 sel=0, cpu_out wdata=0x3C -> out_valid=01, out_data[7:0]=0x3C; second cpu_out 0x55 ignored; out_ready=01 -> out_valid=00, sko skip=1.
REQ-022 IMSK=0x03, ion, input ch1 then ch0 same cycle -> irq=1 next cycle, irq_ch=0; irq_ack -> ien=0, irq=0.
REQ-023 ion and iof same cycle -> ien=0; msk 0x0C after reset with ion -> irq=1, irq_ch=0 (FGO reset to 1).
REQ-024 rst pulse while FGI0=1 and out_valid0=1 -> all values per REQ-017 asynchronously, before next clk edge.
